// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-port unified instruction/data memory between the
//   instruction-fetch port (read-only) and the load/store data port.
//   Fixed priority with data over fetch. Fetch is forced to win once it has
//   lost MAX_WAIT consecutive arbitrations to data.
//   Each access takes one SERVE cycle, in which the memory address, write
//   data and write enable are driven, followed by one RESP cycle, in which
//   the granted requester sees a single-cycle ack.
//
// Parameters
//   DEPTH     number of valid memory words; an address >= DEPTH is out of range
//   MAX_WAIT  consecutive losses fetch tolerates before it is forced to win (1..15)
//
// Ports
//   Clk, Reset                      clock (rising edge), synchronous active-high reset
//   i_req, i_addr                   fetch request and word address
//   i_ack, i_rdata, i_err           fetch completion pulse, read data, out-of-range flag
//   d_req, d_we, d_addr, d_wdata    data request, store select, word address, store data
//   d_ack, d_rdata, d_err           data completion pulse, load data, out-of-range flag
//   mem_addr, mem_wdata, mem_we     memory Address / writeData / writeEnable
//   mem_rdata                       memory MemData (combinational read)
//   conflict_cnt                    exists only when MEM_ARB_PERF_EN is defined; counts
//                                   arbitrations where both requests are high (saturating)
//
// Build option
//   MEM_ARB_PERF_EN  adds the conflict_cnt output and its counter
//
// States
//   state   | meaning
//   IDLE    | waiting for a request; arbitration happens here
//   SERVE_I | memory driven with the fetch address; fetch response captured
//   SERVE_D | memory driven with the data access; data response captured
//   RESP    | ack pulse to the granted requester

module mem_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
  localparam logic [3:0]  MAX_WAIT_W = 4'(MAX_WAIT);

  state_t      state, state_nxt;
  logic        grant_d, grant_d_nxt;   // 1 = data holds the grant, 0 = fetch
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        i_in_range, d_in_range;
  logic        fetch_forced;

  assign i_in_range   = (i_addr < DEPTH_W);
  assign d_in_range   = (d_addr < DEPTH_W);
  assign fetch_forced = i_req && (wait_cnt == MAX_WAIT_W);

  // Ack is a decode of RESP and the latched grant, so a reset during
  // SERVE can never produce a stray ack.
  assign i_ack = (state == RESP) && !grant_d;
  assign d_ack = (state == RESP) &&  grant_d;

  always_comb begin
    state_nxt    = state;
    grant_d_nxt  = grant_d;
    wait_cnt_nxt = wait_cnt;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_we       = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_nxt   = SERVE_D;
          grant_d_nxt = 1'b1;
          if (i_req && (wait_cnt < MAX_WAIT_W)) begin
            wait_cnt_nxt = wait_cnt + 4'd1;
          end
        end else if (i_req) begin
          state_nxt    = SERVE_I;
          grant_d_nxt  = 1'b0;
          wait_cnt_nxt = 4'd0;
        end
      end
      SERVE_I: begin
        mem_addr  = i_addr;
        state_nxt = RESP;
      end
      SERVE_D: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        // Reset gates the enable directly so an abandoned store never lands.
        mem_we    = d_we && d_in_range && !Reset;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      grant_d  <= 1'b0;
      wait_cnt <= 4'd0;
      i_rdata  <= 32'd0;
      i_err    <= 1'b0;
      d_rdata  <= 32'd0;
      d_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_d  <= grant_d_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == SERVE_I) begin
        i_rdata <= i_in_range ? mem_rdata : 32'd0;
        i_err   <= !i_in_range;
      end
      if (state == SERVE_D) begin
        d_rdata <= (!d_we && d_in_range) ? mem_rdata : 32'd0;
        d_err   <= !d_in_range;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      conflict_cnt <= 16'd0;
    end else if ((state == IDLE) && i_req && d_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt;
`endif

  mem_arbiter #(.DEPTH(1024), .MAX_WAIT(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  // Memory model: combinational read, write on rising edge. Out-of-range
  // reads return a marker the arbiter must mask to zero.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'hBAD0_BAD0;

  always @(posedge Clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we && (mem_addr < 32'd1024)) mem[mem_addr[9:0]] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       iq[$];
  resp_t       dq[$];
  logic [31:0] exp_mem [int];
  int          tests = 0;
  int          fails = 0;

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    pl_en = 1'b1; pl_addr = 10'(a); pl_data = v;
    exp_mem[a] = v;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic check_resp(input bit is_d);
    resp_t r;
    if (is_d ? (dq.size() == 0) : (iq.size() == 0)) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      r = is_d ? dq.pop_front() : iq.pop_front();
      chk(is_d ? "d_rdata" : "i_rdata", is_d ? d_rdata : i_rdata, r.rdata);
      chk(is_d ? "d_err" : "i_err", 32'(is_d ? d_err : i_err), 32'(r.err));
      chk("other_ack", 32'(is_d ? i_ack : d_ack), 32'd0);
    end
  endtask

  // Single uncontended access, issued at a negedge while the arbiter is idle.
  task automatic access(input bit is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    resp_t r;
    int    n;
    logic  ack;
    logic  in_range;
    in_range = (addr < 32'd1024);
    r.err    = !in_range;
    r.rdata  = 32'd0;
    if (!we && in_range) r.rdata = exp_mem[int'(addr)];
    if (is_d) begin
      dq.push_back(r);
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      iq.push_back(r);
      i_req = 1'b1; i_addr = addr;
    end
    n = 0;
    ack = 1'b0;
    do begin
      tick();
      n++;
      chk("mem_we", 32'(mem_we), 32'((n == 1) && is_d && we && in_range));
      chk("mem_addr", mem_addr, (n == 1) ? addr : 32'd0);
      chk("mem_wdata", mem_wdata, ((n == 1) && is_d) ? wdata : 32'd0);
      ack = is_d ? d_ack : i_ack;
    end while (!ack && n < 4);
    chk("ack_latency", 32'(n), 32'd2);
    if (ack) check_resp(is_d);
    d_req = 1'b0; i_req = 1'b0;
    if (is_d && we && in_range) exp_mem[int'(addr)] = wdata;
    tick();
    chk("ack_single_cycle", 32'({d_ack, i_ack}), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_acks_errs"}, 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    resp_t r;
    string order;
    string got;
    int    n;
    Reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    preload(0,   32'h1111_0000);
    preload(2,   32'd1);
    preload(3,   32'h0000_0033);
    preload(5,   32'h0000_0055);
    preload(6,   32'h0000_0000);
    preload(128, 32'h8c03_0000);
    check_all_zero("reset");
`ifdef MEM_ARB_PERF_EN
    chk("conflict_reset", 32'(conflict_cnt), 32'd0);
`endif
    Reset = 1'b0;
    tick();

    // load after reset
    access(1, 1'b0, 32'd2, 32'd0);
    // store then fetch of the stored word
    access(1, 1'b1, 32'd6, 32'hDEAD_BEEF);
    access(0, 1'b0, 32'd6, 32'd0);
    // out-of-range store, then confirm no aliasing into low memory
    access(1, 1'b1, 32'd1024, 32'h1234_5678);
    access(0, 1'b0, 32'd0, 32'd0);
    // out-of-range fetch and load must mask the memory data
    access(0, 1'b0, 32'd1500, 32'd0);
    access(1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    // boundary: last valid word
    access(1, 1'b1, 32'd1023, 32'hA5A5_0001);
    access(1, 1'b0, 32'd1023, 32'd0);

    // contention with starvation guard
    order = "DDDIDDDI";
    for (int k = 0; k < 6; k++) begin
      r.rdata = exp_mem[3]; r.err = 1'b0; dq.push_back(r);
    end
    for (int k = 0; k < 2; k++) begin
      r.rdata = 32'h8c03_0000; r.err = 1'b0; iq.push_back(r);
    end
    i_req = 1'b1; i_addr = 32'd128;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd3;
    for (int g = 0; g < 8; g++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!i_ack && !d_ack && n < 5);
      got = d_ack ? "D" : (i_ack ? "I" : "-");
      chk("grant_order", 32'(got[0]), 32'(order[g]));
      chk("grant_gap", 32'(n), (g == 0) ? 32'd2 : 32'd3);
      if (d_ack || i_ack) check_resp(d_ack);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    chk("contention_quiet", 32'({d_ack, i_ack}), 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'd8);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("conflict_after_reset", 32'(conflict_cnt), 32'd0);
`endif
    tick();

    // reset during the SERVE cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd5; d_wdata = 32'hCAFE_F00D;
    tick();
    chk("serve_d_we", 32'(mem_we), 32'd1);
    Reset = 1'b1;
    #1;
    chk("reset_gates_we", 32'(mem_we), 32'd0);
    tick();
    check_all_zero("mid_reset");
    Reset = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_ack_after_reset", 32'({d_ack, i_ack}), 32'd0);
    end
    access(0, 1'b0, 32'd5, 32'd0);

    chk("scoreboard_drained", 32'(iq.size() + dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
